// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared types and default constants for the IO bank controller.
//   bank_state_e   - power sequencing states
//   *_DEF          - default parameter values
//   *_W            - counter widths
package io_bank_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ON     = 2'd2
   } bank_state_e;

   localparam int NCH_DEF        = 16;
   localparam int DEB_CYC_DEF    = 4;
   localparam int SETTLE_CYC_DEF = 64;

   localparam int DEB_CNT_W    = 8;
   localparam int SETTLE_CNT_W = 16;

endpackage

// File: rtl/io_bank_if.sv
// io_bank_if: pad-cell bus of the IO bank.
//   pad_a    ctrl->pad  output value
//   pad_en   ctrl->pad  output enable, active low (0 = drive)
//   pad_puen ctrl->pad  pull-up enable
//   pad_pden ctrl->pad  pull-down enable
//   pad_y    pad->ctrl  pad input, asynchronous to clk
interface io_bank_if
   import io_bank_pkg::*;
#(
   parameter int NCH = NCH_DEF
);
   logic [NCH-1:0] pad_a;
   logic [NCH-1:0] pad_en;
   logic [NCH-1:0] pad_puen;
   logic [NCH-1:0] pad_pden;
   logic [NCH-1:0] pad_y;

   modport ctrl (output pad_a, pad_en, pad_puen, pad_pden, input pad_y);
   modport pad  (input pad_a, pad_en, pad_puen, pad_pden, output pad_y);
endinterface

// File: rtl/io_in_filter.sv
// io_in_filter: one input channel - 2-flop synchroniser, optional debounce,
// rising-edge interrupt pending flag.
//   clk, resetn  bank clock, async active-low reset
//   run          bank is ON; when low the synchroniser/counter are held clear
//                and in_val/irq_pend hold their value
//   pad_y        asynchronous pad input
//   deb_en       debounce enable (low also clears the counter)
//   irq_en       rising-edge interrupt enable
//   irq_clr      write-1-to-clear pulse for irq_pend
//   in_val       filtered input value
//   irq_pend     interrupt pending
module io_in_filter
   import io_bank_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   input  logic pad_y,
   input  logic deb_en,
   input  logic irq_en,
   input  logic irq_clr,
   output logic in_val,
   output logic irq_pend
);

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYC - 1);

   logic                 sync_1;
   logic                 sync_2;
   logic [DEB_CNT_W-1:0] deb_cnt;
   logic [DEB_CNT_W-1:0] cnt_nxt;
   logic                 in_nxt;

   // Counter only advances while the synced value disagrees; any agreement
   // (or debounce disabled) restarts it, so a toggle of deb_en clears it.
   always_comb begin
      in_nxt  = in_val;
      cnt_nxt = '0;
      if (!deb_en) begin
         in_nxt = sync_2;
      end else if (sync_2 != in_val) begin
         if (deb_cnt == DEB_LAST) begin
            in_nxt = sync_2;
         end else begin
            cnt_nxt = deb_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         deb_cnt  <= '0;
         in_val   <= 1'b0;
         irq_pend <= 1'b0;
      end else if (run) begin
         sync_1   <= pad_y;
         sync_2   <= sync_1;
         deb_cnt  <= cnt_nxt;
         in_val   <= in_nxt;
         // set has priority over a coincident clear
         irq_pend <= (irq_en & in_nxt & ~in_val) | (irq_pend & ~irq_clr);
      end else begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         deb_cnt <= '0;
      end
   end

endmodule

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: IO bank power sequencing and pad control.
//   clk, resetn       bank clock, async active-low reset
//   supply_ok         pad supply good (asynchronous, synchronised here)
//   out_val, oe       per-channel output value / enable (1 = drive)
//   pu, pd            per-channel pull-up / pull-down requests
//   deb_en            per-channel debounce enable
//   irq_en, irq_clr   per-channel rising-edge irq enable / clear pulse
//   in_val            filtered input values
//   irq_pend, irq     per-channel pending flags and their OR
//   bank_ready        bank is ON
//   pads              pad-cell bus (ctrl side)
//
// state     | meaning
// ST_OFF    | supply absent; pads safe (undriven, no pulls), inputs frozen
// ST_SETTLE | supply present, waiting SETTLE_CYC consecutive good cycles
// ST_ON     | pads follow configuration, inputs sampled
module io_bank_ctrl
   import io_bank_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int DEB_CYC    = DEB_CYC_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           supply_ok,
   input  logic [NCH-1:0] out_val,
   input  logic [NCH-1:0] oe,
   input  logic [NCH-1:0] pu,
   input  logic [NCH-1:0] pd,
   input  logic [NCH-1:0] deb_en,
   input  logic [NCH-1:0] irq_en,
   input  logic [NCH-1:0] irq_clr,
   output logic [NCH-1:0] in_val,
   output logic [NCH-1:0] irq_pend,
   output logic           irq,
   output logic           bank_ready,
   io_bank_if.ctrl        pads
);

   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

   logic                    sup_s1;
   logic                    sup_s2;
   bank_state_e             state;
   bank_state_e             state_nxt;
   logic [SETTLE_CNT_W-1:0] settle_cnt;
   logic [SETTLE_CNT_W-1:0] settle_nxt;
   logic                    on_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sup_s1     <= 1'b0;
         sup_s2     <= 1'b0;
         state      <= ST_OFF;
         settle_cnt <= '0;
      end else begin
         sup_s1     <= supply_ok;
         sup_s2     <= sup_s1;
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
      end
   end

   // Settle timer is a down-counter loaded on SETTLE entry; reaching zero
   // with supply still good marks the last of SETTLE_CYC cycles.
   always_comb begin
      state_nxt  = state;
      settle_nxt = '0;
      case (state)
         ST_OFF: begin
            if (sup_s2) begin
               state_nxt  = ST_SETTLE;
               settle_nxt = SETTLE_LAST;
            end
         end
         ST_SETTLE: begin
            if (!sup_s2) begin
               state_nxt = ST_OFF;
            end else if (settle_cnt == '0) begin
               state_nxt = ST_ON;
            end else begin
               settle_nxt = settle_cnt - 1'b1;
            end
         end
         ST_ON: begin
            if (!sup_s2) state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   // Pad registers follow the next state so the pads go safe on the same
   // edge the FSM leaves ON, not one cycle later.
   assign on_nxt = (state_nxt == ST_ON);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pads.pad_a    <= '0;
         pads.pad_en   <= '1;
         pads.pad_puen <= '0;
         pads.pad_pden <= '0;
      end else if (on_nxt) begin
         pads.pad_a    <= out_val;
         pads.pad_en   <= ~oe;
         pads.pad_puen <= pu & ~pd;
         pads.pad_pden <= pd & ~pu;
      end else begin
         pads.pad_a    <= '0;
         pads.pad_en   <= '1;
         pads.pad_puen <= '0;
         pads.pad_pden <= '0;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      io_in_filter #(.DEB_CYC(DEB_CYC)) u_filt (
         .clk      (clk),
         .resetn   (resetn),
         .run      (state == ST_ON),
         .pad_y    (pads.pad_y[g]),
         .deb_en   (deb_en[g]),
         .irq_en   (irq_en[g]),
         .irq_clr  (irq_clr[g]),
         .in_val   (in_val[g]),
         .irq_pend (irq_pend[g])
      );
   end

   assign irq        = |irq_pend;
   assign bank_ready = (state == ST_ON);

endmodule

// File: doc/io_bank_ctrl.md
IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 Parameter NCH, default 16, number of pad channels (1..32).
REQ-002 Parameter DEB_CYC, default 4, consecutive disagreeing cycles needed to accept a filtered input (1..255).
REQ-003 Parameter SETTLE_CYC, default 64, cycles supply_ok must stay high before the bank is enabled (1..65535).
REQ-004 clk  in  1  single bank clock; all flops on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 supply_ok  in  1  pad-supply good from the supply checker; asynchronous to clk, used only after a 2-flop synchroniser.
REQ-007 out_val  in  NCH  per-channel output value.
REQ-008 oe  in  NCH  per-channel output enable, 1 = drive.
REQ-009 pu, pd  in  NCH each  per-channel pull-up / pull-down request.
REQ-010 deb_en  in  NCH  per-channel debounce enable.
REQ-011 irq_en  in  NCH  per-channel rising-edge interrupt enable.
REQ-012 irq_clr  in  NCH  per-channel write-1-to-clear pulse.
REQ-013 pad_a, pad_en, pad_puen, pad_pden  out  NCH each  to pad cells; pad_en is active-low (0 = drive).
REQ-014 pad_y  in  NCH  from pad cells, asynchronous.
REQ-015 in_val  out  NCH  synchronised, optionally debounced, input value.
REQ-016 irq_pend  out  NCH; irq  out  1  OR of irq_pend.
REQ-017 bank_ready  out  1  high only in state ON.

Function
REQ-018 The FSM SHALL have states OFF, SETTLE and ON.
REQ-019 OFF->SETTLE when synced supply_ok=1; SETTLE->ON after SETTLE_CYC consecutive high cycles; any state->OFF on the cycle after synced supply_ok=0 (counter cleared).
REQ-020 In OFF/SETTLE: pad_en all 1, pad_a/pad_puen/pad_pden all 0, synchronisers and debounce counters held clear, in_val and irq_pend frozen.
REQ-021 In ON, pad outputs are registered: pad_a=out_val, pad_en=~oe, one cycle after the inputs change.
REQ-022 pad_puen=pu&~pd, pad_pden=pd&~pu; pu=pd=1 yields neither pull.
REQ-023 pad_y passes a 2-flop synchroniser to signal s; with deb_en=0, in_val<=s each cycle (pad-to-in_val latency 3 edges).
REQ-024 With deb_en=1, a per-channel counter increments while s!=in_val and clears when equal; when the count equals DEB_CYC-1 and s!=in_val, in_val<=s and the counter clears (latency 2+DEB_CYC edges).
REQ-025 A 0->1 transition of in_val with irq_en=1 sets irq_pend; irq_clr=1 clears it; set wins on the same cycle.
REQ-026 Toggling deb_en mid-count SHALL clear that channel's counter.

Reset
REQ-027 On resetn=0, asynchronously: state=OFF, all counters 0, in_val=0, irq_pend=0, irq=0, bank_ready=0, pad_en all 1, pad_a/pad_puen/pad_pden all 0.
REQ-028 Reset deassertion mid-SETTLE restarts from OFF.

Structure
REQ-029 Package io_bank_pkg SHALL hold the state enum and default parameter constants.
REQ-030 Sub-module io_in_filter SHALL implement one channel's synchroniser, debounce and edge detect; it is instantiated NCH times.

Verification
REQ-031 Power-up: supply_ok rises with SETTLE_CYC=64 -> bank_ready rises 64 cycles after SETTLE entry; pad_en stays all 1 until then.
REQ-032 Brown-out: supply_ok=0 for 3 cycles while ON with oe=all 1 -> pad_en=all 1 within 3 edges (sync+1), bank_ready=0, SETTLE repeats in full.
REQ-033 Debounce: DEB_CYC=4, deb_en=1, pad_y pulses high for 3 cycles -> in_val unchanged; high for 4 cycles -> in_val=1 at edge 6.
REQ-034 Pull conflict: pu=pd=1 -> pad_puen=pad_pden=0; pu=1, pd=0 -> pad_puen=1 on the next cycle.
REQ-035 IRQ: irq_en=1, rising in_val coincides with irq_clr=1 -> irq_pend stays 1; a later irq_clr clears it and irq falls.
REQ-036 Async reset asserted mid-ON -> all outputs at their REQ-027 values without a clock edge.
